// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } muldiv_state_e;

  function automatic logic op_is_div(muldiv_op_e o);
    return (o == MD_DIV) || (o == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(muldiv_op_e o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit with architectural HI/LO registers.
// Magnitudes are processed unsigned; signs are applied in the FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  muldiv_state_e      state_q, state_d;
  muldiv_op_e         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  muldiv_op_e         op_in;
  logic               in_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               cur_div;
  logic [WIDTH+1:0]   add_a, add_b, add_sum;
  logic               add_cin;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quot, rem;

  assign op_in   = muldiv_op_e'(op);
  assign in_div  = op_is_div(op_in);
  assign a_neg   = op_is_signed(op_in) & A[WIDTH-1];
  assign b_neg   = op_is_signed(op_in) & B[WIDTH-1];
  assign a_abs   = a_neg ? -A : A;
  assign b_abs   = b_neg ? -B : B;
  assign cur_div = op_is_div(op_q);

  // Single shared adder: add multiplicand for mul, subtract divisor for div.
  always_comb begin
    if (cur_div) begin
      add_a   = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]};
      add_b   = ~{2'b00, opd_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {2'b00, acc_q[2*WIDTH-1:WIDTH]};
      add_b   = acc_q[0] ? {2'b00, opd_q} : '0;
      add_cin = 1'b0;
    end
    add_sum = add_a + add_b + {{(WIDTH+1){1'b0}}, add_cin};
  end

  always_comb begin
    if (!cur_div) begin
      acc_step = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
    end else if (add_sum[WIDTH+1]) begin
      // Trial subtraction went negative: restore by shifting only.
      acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  assign prod_fix = q_neg_q ? -acc_q : acc_q;
  assign quot     = q_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem      = r_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opd_d      = opd_q;
    a_orig_d   = a_orig_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    b_zero_d   = b_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          op_d       = op_in;
          opd_d      = in_div ? b_abs : a_abs;
          acc_d      = {{WIDTH{1'b0}}, (in_div ? a_abs : b_abs)};
          a_orig_d   = A;
          b_zero_d   = (B == '0);
          q_neg_d    = a_neg ^ b_neg;
          r_neg_d    = a_neg;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          state_d    = MD_CALC;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      MD_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        if (!cur_div) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_zero_q) begin
          lo_d       = '1;
          hi_d       = a_orig_q;
          div_zero_d = 1'b1;
        end else begin
          lo_d = quot;
          hi_d = rem;
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= MD_IDLE;
      op_q       <= MD_MULT;
      cnt_q      <= '0;
      acc_q      <= '0;
      opd_q      <= '0;
      a_orig_q   <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      b_zero_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opd_q      <= opd_d;
      a_orig_q   <= a_orig_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      b_zero_q   <= b_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != MD_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset div_zero", {63'd0, div_zero}, 64'd0);
    check("reset HI", {32'd0, HI}, 64'd0);
    check("reset LO", {32'd0, LO}, 64'd0);
    #11 RST = 1'b1;
    tick();

    // MULTU max * max
    issue(OP_MULTU, 32'hffffffff, 32'hffffffff);
    check("multu busy after start", {63'd0, busy}, 64'd1);
    wait_done(cycles);
    check("multu latency", 64'(cycles), 64'd33);
    check("multu busy low at done", {63'd0, busy}, 64'd0);
    check("multu HI", {32'd0, HI}, 64'hfffffffe);
    check("multu LO", {32'd0, LO}, 64'h00000001);
    tick();
    check("done single pulse", {63'd0, done}, 64'd0);

    // MULT -2*3, then back-to-back DIV -7/2 from the done cycle
    issue(OP_MULT, 32'hfffffffe, 32'h00000003);
    wait_done(cycles);
    check("mult HI", {32'd0, HI}, 64'hffffffff);
    check("mult LO", {32'd0, LO}, 64'hfffffffa);
    issue(OP_DIV, 32'hfffffff9, 32'h00000002);
    check("b2b accepted", {63'd0, busy}, 64'd1);
    wait_done(cycles);
    check("b2b div latency", 64'(cycles), 64'd33);
    check("div -7/2 LO", {32'd0, LO}, 64'hfffffffd);
    check("div -7/2 HI", {32'd0, HI}, 64'hffffffff);

    // DIVU by zero
    issue(OP_DIVU, 32'h00000064, 32'h00000000);
    wait_done(cycles);
    check("div0 latency", 64'(cycles), 64'd33);
    check("div0 LO", {32'd0, LO}, 64'hffffffff);
    check("div0 HI", {32'd0, HI}, 64'h00000064);
    check("div0 flag", {63'd0, div_zero}, 64'd1);
    tick();
    check("div0 flag sticky", {63'd0, div_zero}, 64'd1);

    // MIN / -1 signed and unsigned
    issue(OP_DIV, 32'h80000000, 32'hffffffff);
    check("start clears div_zero", {63'd0, div_zero}, 64'd0);
    wait_done(cycles);
    check("min/-1 LO", {32'd0, LO}, 64'h80000000);
    check("min/-1 HI", {32'd0, HI}, 64'h00000000);
    check("min/-1 no flag", {63'd0, div_zero}, 64'd0);
    issue(OP_DIVU, 32'h80000000, 32'hffffffff);
    wait_done(cycles);
    check("divu LO", {32'd0, LO}, 64'h00000000);
    check("divu HI", {32'd0, HI}, 64'h80000000);

    // start and MTHI while busy are both ignored
    issue(OP_MULTU, 32'd7, 32'd6);
    repeat (4) tick();
    start = 1'b1; op = OP_DIVU; A = 32'd1000; B = 32'd3;
    hi_we = 1'b1; wdata = 32'hdead0000;
    tick();
    start = 1'b0; hi_we = 1'b0;
    wait_done(cycles);
    check("busy-start latency", 64'(cycles), 64'd28);
    check("busy-start HI", {32'd0, HI}, 64'h00000000);
    check("busy-start LO", {32'd0, LO}, 64'h0000002a);

    // MTHI in idle, then start beats MTLO
    hi_we = 1'b1; wdata = 32'h12345678;
    tick();
    hi_we = 1'b0;
    check("mthi HI", {32'd0, HI}, 64'h12345678);
    check("mthi LO unchanged", {32'd0, LO}, 64'h0000002a);
    lo_we = 1'b1; wdata = 32'h55555555;
    issue(OP_MULTU, 32'd2, 32'd2);
    lo_we = 1'b0;
    check("start wins busy", {63'd0, busy}, 64'd1);
    check("start wins LO", {32'd0, LO}, 64'h0000002a);
    wait_done(cycles);
    check("start wins result LO", {32'd0, LO}, 64'h00000004);
    check("start wins result HI", {32'd0, HI}, 64'h00000000);

    // Asynchronous reset mid-operation
    hi_we = 1'b1; wdata = 32'h0000abcd;
    tick();
    hi_we = 1'b0;
    issue(OP_MULT, 32'd5, 32'd7);
    repeat (9) tick();
    #2 RST = 1'b0;
    #1;
    check("async rst busy", {63'd0, busy}, 64'd0);
    check("async rst done", {63'd0, done}, 64'd0);
    check("async rst HI", {32'd0, HI}, 64'd0);
    check("async rst LO", {32'd0, LO}, 64'd0);
    #2 RST = 1'b1;
    tick();
    issue(OP_MULTU, 32'd3, 32'd5);
    wait_done(cycles);
    check("post rst latency", 64'(cycles), 64'd33);
    check("post rst LO", {32'd0, LO}, 64'h0000000f);
    check("post rst HI", {32'd0, HI}, 64'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
